mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-port arbiter and sequencer sharing the SoC's single-ported instruction/data memory between the ICache refill engine and the DCache/LSU word port. It sits between the rv32 core's cache miss interfaces and the memory slave:
- It grants one requester at a time, using round-robin on ties.
- It sequences an ICache line refill as a LINE_WORDS-beat read burst.
- It runs single-word DCache reads and writes.
- It returns read data beat by beat with a completion pulse.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (wstrb is DATA_W/8)
- LINE_WORDS, 4, ICache line length in words (power of 2, ≥2)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ic_req  in  1  ICache refill request; held until ic_gnt
- ic_addr  in  ADDR_W  refill address; low log2(LINE_WORDS*4) bits ignored
- ic_gnt  out  1  one-cycle grant pulse
- ic_rvalid  out  1  refill beat valid
- ic_rdata  out  DATA_W  refill beat data, in ascending word order
- ic_done  out  1  pulses with the last ic_rvalid
- dc_req  in  1  DCache word request; held until dc_gnt
- dc_we  in  1  1 = write, 0 = read
- dc_addr  in  ADDR_W  word address; bits [1:0] ignored
- dc_wdata  in  DATA_W  write data
- dc_wstrb  in  DATA_W/8  byte enables for writes
- dc_gnt  out  1  one-cycle grant pulse
- dc_rvalid  out  1  read data valid; never asserted for writes
- dc_rdata  out  DATA_W  read data
- dc_done  out  1  access complete (reads and writes)
- mem_req  out  1  memory beat request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  beat address, word aligned
- mem_wdata  out  DATA_W  write data
- mem_wstrb  out  DATA_W/8  byte enables; 0 for reads
- mem_ready  in  1  beat accepted/completed this cycle; mem_rdata is valid in the same cycle
- mem_rdata  in  DATA_W  read data

## Operation
- FSM states:
  - IDLE
  - IC_BURST
  - DC_ACCESS
- IDLE, evaluated every cycle:
  - If only one requester is active, that requester wins.
  - If both are active, the requester that did not win the last grant wins. The last_dc flag resets to 0, so the DCache wins the first tie.
  - The winner's address and write data are latched, its gnt is pulsed, and the FSM enters IC_BURST or DC_ACCESS.
- IC_BURST:
  - mem_req=1, mem_we=0.
  - mem_addr = line_base + 4*beat.
  - Beat counter width is log2(LINE_WORDS) and it starts at 0.
  - Each mem_ready advances the beat.
  - mem_ready on the beat LINE_WORDS-1 returns the FSM to IDLE.
- DC_ACCESS:
  - mem_req=1, with mem_we, mem_wdata and mem_wstrb taken from the latched values.
  - mem_ready returns the FSM to IDLE.
- Once granted, the requester's req and addr inputs are ignored until its done pulse. Deasserting req mid-transaction does not abort it.
- mem_addr never wraps within a line: line_base is aligned, so there is no carry out of the offset field.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, last_dc=0, and the beat counter is 0.
- Reset asserted mid-burst aborts immediately. No done pulse is produced, and any partial data is discarded by the requester.
- All outputs are registered, except that mem_* is driven from state and latched registers with no combinational path from requester inputs.
- Grant timing: a request sampled in IDLE at edge N produces gnt high and mem_req high in cycle N+1. gnt stays high for exactly one cycle.
- mem_ready sampled at edge M produces rvalid/rdata in cycle M+1, and done in cycle M+1 for the final beat.
- Minimum refill latency, with mem_ready tied high:
  - 1 cycle to grant.
  - LINE_WORDS beats.
  - The last rvalid arrives LINE_WORDS+1 cycles after the request is sampled.
- Turnaround: after the final mem_ready the FSM spends one cycle in IDLE, so back-to-back grants are 1 idle cycle apart. mem_req is low for that cycle.
- mem_ready while mem_req=0 is ignored.
- A request arriving mid-transaction waits and is evaluated in the next IDLE cycle.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, IC_BURST, DC_ACCESS);
  - the LINE_WORDS default;
  - the beat-counter width function;
  - the line-offset width constant.
- One sub-module, mem_arb_rr2, is the combinational two-way round-robin pick from (ic_req, dc_req, last_dc). Its outputs are pick_ic and pick_dc.
- Everything else lives in mem_bus_arbiter.

## Test plan
- Reset then lone refill:
  - Stimulus: ic_addr=0x0000_001C, mem_ready=1.
  - Required: mem_addr 0x10, 0x14, 0x18, 0x1C on consecutive cycles; 4 ic_rvalid beats with the ROM words; ic_done on the 4th.
- Simultaneous ic_req and dc_req after reset:
  - Required: dc granted first (dc_gnt at N+1), ic_gnt follows 1 idle cycle after dc_done.
  - Repeating the tie must grant ic first.
- DC write:
  - Stimulus: dc_addr=0x2003, dc_wdata=0xDEADBEEF, wstrb=0b0011.
  - Required: mem_addr=0x2000, mem_we=1, mem_wstrb=0b0011; dc_done with dc_rvalid=0.
- Memory wait states:
  - Stimulus: mem_ready alternating 0/1 during a refill.
  - Required: the address holds while ready=0; exactly 4 rvalid beats; ic_done after 8 mem_req cycles.
- rst asserted during beat 2 of a refill:
  - Required: all outputs 0 that cycle; no ic_done; the next ic_req restarts at beat 0.
- ic_req dropped after grant:
  - Required: the burst still completes all 4 beats with ic_done.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the ICache/DCache memory bus
//                arbiter (state encoding, line geometry helpers).
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        IC_BURST  = 2'd1,
        DC_ACCESS = 2'd2
    } arb_state_e;

    // Default ICache line length in 32-bit words
    localparam int C_LINE_WORDS = 4;

    // Width of the beat counter that walks one refill line
    function automatic int beat_cnt_w(input int line_words);
        return (line_words > 1) ? $clog2(line_words) : 1;
    endfunction

    // Width of the byte-offset field inside one line
    function automatic int line_off_w(input int line_words);
        return $clog2(line_words * 4);
    endfunction

    // Byte-offset width for the default line geometry
    localparam int C_LINE_OFF_W = $clog2(C_LINE_WORDS * 4);

endpackage
`default_nettype wire

// File: rtl/mem_arb_rr2.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_rr2
//  Description : Combinational two-way round-robin pick between the ICache
//                and DCache requesters. On a tie, the side that did not win
//                the previous grant is chosen.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arb_rr2 (
    input  logic ic_req,
    input  logic dc_req,
    input  logic last_dc,
    output logic pick_ic,
    output logic pick_dc
);

    // Lone requester wins outright; a tie goes to whoever lost last time
    always_comb begin
        pick_ic = ic_req & (~dc_req | last_dc);
        pick_dc = dc_req & (~ic_req | ~last_dc);
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Shares a single-ported memory between the ICache refill
//                engine (LINE_WORDS-beat read bursts) and the DCache word
//                port (single reads/writes). Grants are round-robin on ties,
//                all requester-facing outputs are registered, and the memory
//                side is driven only from state and latched registers.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = C_LINE_WORDS
) (
    input  logic                  clk,
    input  logic                  rst,
    // ICache refill port
    input  logic                  ic_req,
    input  logic [ADDR_W-1:0]     ic_addr,
    output logic                  ic_gnt,
    output logic                  ic_rvalid,
    output logic [DATA_W-1:0]     ic_rdata,
    output logic                  ic_done,
    // DCache word port
    input  logic                  dc_req,
    input  logic                  dc_we,
    input  logic [ADDR_W-1:0]     dc_addr,
    input  logic [DATA_W-1:0]     dc_wdata,
    input  logic [DATA_W/8-1:0]   dc_wstrb,
    output logic                  dc_gnt,
    output logic                  dc_rvalid,
    output logic [DATA_W-1:0]     dc_rdata,
    output logic                  dc_done,
    // Memory slave port
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_ready,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int C_STRB_W = DATA_W / 8;
    localparam int C_BEAT_W = beat_cnt_w(LINE_WORDS);
    localparam int C_OFF_W  = line_off_w(LINE_WORDS);

    localparam logic [C_BEAT_W-1:0] C_LAST_BEAT = C_BEAT_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0]   C_LINE_MASK = {{(ADDR_W-C_OFF_W){1'b1}}, {C_OFF_W{1'b0}}};
    localparam logic [ADDR_W-1:0]   C_WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    arb_state_e             state_q, state_d;
    logic                   last_dc_q, last_dc_d;
    logic [C_BEAT_W-1:0]    beat_q, beat_d;
    logic [ADDR_W-1:0]      ic_base_q, ic_base_d;
    logic [ADDR_W-1:0]      dc_addr_q, dc_addr_d;
    logic                   dc_we_q, dc_we_d;
    logic [DATA_W-1:0]      dc_wdata_q, dc_wdata_d;
    logic [C_STRB_W-1:0]    dc_wstrb_q, dc_wstrb_d;

    logic                   ic_gnt_q, ic_gnt_d;
    logic                   ic_rvalid_q, ic_rvalid_d;
    logic [DATA_W-1:0]      ic_rdata_q, ic_rdata_d;
    logic                   ic_done_q, ic_done_d;
    logic                   dc_gnt_q, dc_gnt_d;
    logic                   dc_rvalid_q, dc_rvalid_d;
    logic [DATA_W-1:0]      dc_rdata_q, dc_rdata_d;
    logic                   dc_done_q, dc_done_d;

    logic                   pick_ic;
    logic                   pick_dc;
    logic [ADDR_W-1:0]      beat_off;

    mem_arb_rr2 u_rr2 (
        .ic_req  (ic_req),
        .dc_req  (dc_req),
        .last_dc (last_dc_q),
        .pick_ic (pick_ic),
        .pick_dc (pick_dc)
    );

    // Next-state, latch capture and registered-output computation
    always_comb begin
        state_d     = state_q;
        last_dc_d   = last_dc_q;
        beat_d      = beat_q;
        ic_base_d   = ic_base_q;
        dc_addr_d   = dc_addr_q;
        dc_we_d     = dc_we_q;
        dc_wdata_d  = dc_wdata_q;
        dc_wstrb_d  = dc_wstrb_q;
        ic_gnt_d    = 1'b0;
        ic_rvalid_d = 1'b0;
        ic_rdata_d  = ic_rdata_q;
        ic_done_d   = 1'b0;
        dc_gnt_d    = 1'b0;
        dc_rvalid_d = 1'b0;
        dc_rdata_d  = dc_rdata_q;
        dc_done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                beat_d = '0;
                if (pick_ic) begin
                    state_d   = IC_BURST;
                    ic_gnt_d  = 1'b1;
                    last_dc_d = 1'b0;
                    ic_base_d = ic_addr & C_LINE_MASK;
                end else if (pick_dc) begin
                    state_d    = DC_ACCESS;
                    dc_gnt_d   = 1'b1;
                    last_dc_d  = 1'b1;
                    dc_addr_d  = dc_addr & C_WORD_MASK;
                    dc_we_d    = dc_we;
                    dc_wdata_d = dc_wdata;
                    dc_wstrb_d = dc_wstrb;
                end
            end
            IC_BURST: begin
                if (mem_ready) begin
                    ic_rvalid_d = 1'b1;
                    ic_rdata_d  = mem_rdata;
                    beat_d      = beat_q + C_BEAT_W'(1);
                    if (beat_q == C_LAST_BEAT) begin
                        ic_done_d = 1'b1;
                        beat_d    = '0;
                        state_d   = IDLE;
                    end
                end
            end
            DC_ACCESS: begin
                if (mem_ready) begin
                    dc_done_d = 1'b1;
                    state_d   = IDLE;
                    if (!dc_we_q) begin
                        dc_rvalid_d = 1'b1;
                        dc_rdata_d  = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory-side drive: depends only on state and latched registers
    always_comb begin
        beat_off                 = '0;
        beat_off[C_BEAT_W+1:2]   = beat_q;
        mem_req   = (state_q != IDLE);
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (state_q == IC_BURST) begin
            mem_addr = ic_base_q | beat_off;
        end else if (state_q == DC_ACCESS) begin
            mem_we    = dc_we_q;
            mem_addr  = dc_addr_q;
            mem_wdata = dc_wdata_q;
            mem_wstrb = dc_we_q ? dc_wstrb_q : '0;
        end
    end

    // State, latched request fields and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_dc_q   <= 1'b0;
            beat_q      <= '0;
            ic_base_q   <= '0;
            dc_addr_q   <= '0;
            dc_we_q     <= 1'b0;
            dc_wdata_q  <= '0;
            dc_wstrb_q  <= '0;
            ic_gnt_q    <= 1'b0;
            ic_rvalid_q <= 1'b0;
            ic_rdata_q  <= '0;
            ic_done_q   <= 1'b0;
            dc_gnt_q    <= 1'b0;
            dc_rvalid_q <= 1'b0;
            dc_rdata_q  <= '0;
            dc_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_dc_q   <= last_dc_d;
            beat_q      <= beat_d;
            ic_base_q   <= ic_base_d;
            dc_addr_q   <= dc_addr_d;
            dc_we_q     <= dc_we_d;
            dc_wdata_q  <= dc_wdata_d;
            dc_wstrb_q  <= dc_wstrb_d;
            ic_gnt_q    <= ic_gnt_d;
            ic_rvalid_q <= ic_rvalid_d;
            ic_rdata_q  <= ic_rdata_d;
            ic_done_q   <= ic_done_d;
            dc_gnt_q    <= dc_gnt_d;
            dc_rvalid_q <= dc_rvalid_d;
            dc_rdata_q  <= dc_rdata_d;
            dc_done_q   <= dc_done_d;
        end
    end

    assign ic_gnt    = ic_gnt_q;
    assign ic_rvalid = ic_rvalid_q;
    assign ic_rdata  = ic_rdata_q;
    assign ic_done   = ic_done_q;
    assign dc_gnt    = dc_gnt_q;
    assign dc_rvalid = dc_rvalid_q;
    assign dc_rdata  = dc_rdata_q;
    assign dc_done   = dc_done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_arbiter
//  Description : Self-checking bench for mem_bus_arbiter: directed vector
//                table, multi-cycle corner sequences and randomized traffic
//                against a transaction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LW     = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_req, ic_gnt, ic_rvalid, ic_done;
    logic [31:0] ic_addr, ic_rdata;
    logic        dc_req, dc_we, dc_gnt, dc_rvalid, dc_done;
    logic [31:0] dc_addr, dc_wdata, dc_rdata;
    logic [3:0]  dc_wstrb;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_rvalid(ic_rvalid),
        .ic_rdata(ic_rdata), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_wstrb(dc_wstrb), .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
        .dc_done(dc_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory content: a fixed scramble of the address
    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    assign mem_rdata = rom(mem_addr);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Observation logs
    int          cyc = 0;
    int          ready_mode = 0;
    int          req_cnt, hold_err, proto_err, idle_err;
    int          ic_done_n, dc_done_n;
    int          ic_gnt_cyc, dc_gnt_cyc, ic_done_cyc, dc_done_cyc, last_ic_rv_cyc;
    bit          prev_pending;
    logic [31:0] prev_addr;
    logic [31:0] acc_addr[$];
    logic        acc_we[$];
    logic [3:0]  acc_strb[$];
    logic [31:0] acc_wdata[$];
    logic [31:0] ic_data[$];
    logic [31:0] dc_data[$];
    int          gnt_log[$];

    // Reference model expectations
    bit          m_last_dc = 1'b0;
    int          e_n_ic, e_n_dc;
    logic [31:0] e_addr[$];
    logic        e_we[$];
    logic [3:0]  e_strb[$];
    logic [31:0] e_wdata[$];
    logic [31:0] e_ic_data[$];
    logic [31:0] e_dc_data[$];
    int          e_gnt[$];

    task automatic clear_logs();
        req_cnt = 0; hold_err = 0; proto_err = 0; idle_err = 0;
        ic_done_n = 0; dc_done_n = 0;
        ic_gnt_cyc = -1; dc_gnt_cyc = -1; ic_done_cyc = -1; dc_done_cyc = -1;
        last_ic_rv_cyc = -1; prev_pending = 1'b0; prev_addr = '0;
        acc_addr.delete(); acc_we.delete(); acc_strb.delete(); acc_wdata.delete();
        ic_data.delete(); dc_data.delete(); gnt_log.delete();
        e_n_ic = 0; e_n_dc = 0;
        e_addr.delete(); e_we.delete(); e_strb.delete(); e_wdata.delete();
        e_ic_data.delete(); e_dc_data.delete(); e_gnt.delete();
    endtask

    // One clock: observe outputs, play the requester and memory roles
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (ic_gnt && dc_gnt) proto_err++;
        if (ic_gnt) begin
            gnt_log.push_back(0);
            ic_gnt_cyc = cyc;
            if (!(mem_req && !mem_we)) proto_err++;
            ic_req  = 1'b0;
            ic_addr = $urandom;
        end
        if (dc_gnt) begin
            gnt_log.push_back(1);
            dc_gnt_cyc = cyc;
            if (!mem_req) proto_err++;
            dc_req   = 1'b0;
            dc_addr  = $urandom;
            dc_wdata = $urandom;
            dc_we    = 1'($urandom);
            dc_wstrb = 4'($urandom);
        end
        if (ic_rvalid) begin
            ic_data.push_back(ic_rdata);
            last_ic_rv_cyc = cyc;
        end
        if (ic_done) begin
            ic_done_n++;
            ic_done_cyc = cyc;
            if (!ic_rvalid) proto_err++;
            if (mem_req) idle_err++;
        end
        if (dc_rvalid) begin
            dc_data.push_back(dc_rdata);
            if (!dc_done) proto_err++;
        end
        if (dc_done) begin
            dc_done_n++;
            dc_done_cyc = cyc;
            if (mem_req) idle_err++;
        end
        case (ready_mode)
            0:       mem_ready = 1'b1;
            1:       mem_ready = mem_req && (req_cnt % 2 == 1);
            default: mem_ready = ($urandom_range(0, 9) < 7);
        endcase
        if (prev_pending && mem_req && (mem_addr !== prev_addr)) hold_err++;
        if (mem_req) req_cnt++;
        if (mem_req && mem_ready) begin
            acc_addr.push_back(mem_addr);
            acc_we.push_back(mem_we);
            acc_strb.push_back(mem_wstrb);
            acc_wdata.push_back(mem_wdata);
        end
        prev_pending = mem_req && !mem_ready;
        prev_addr    = mem_addr;
    endtask

    task automatic launch_ic(input logic [31:0] a);
        ic_addr = a;
        ic_req  = 1'b1;
    endtask

    task automatic launch_dc(input logic we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] st);
        dc_we    = we;
        dc_addr  = a;
        dc_wdata = wd;
        dc_wstrb = st;
        dc_req   = 1'b1;
    endtask

    // Model: a granted refill reads LW ascending words of the aligned line
    task automatic expect_ic(input logic [31:0] a);
        logic [31:0] base;
        base = a & ~32'(LW * 4 - 1);
        for (int i = 0; i < LW; i++) begin
            e_addr.push_back(base + 32'(4 * i));
            e_we.push_back(1'b0);
            e_strb.push_back(4'h0);
            e_wdata.push_back(32'h0);
            e_ic_data.push_back(rom(base + 32'(4 * i)));
        end
        e_n_ic++;
        e_gnt.push_back(0);
        m_last_dc = 1'b0;
    endtask

    // Model: a granted DCache access is one aligned word beat
    task automatic expect_dc(input logic we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] st);
        e_addr.push_back(a & ~32'h3);
        e_we.push_back(we);
        e_strb.push_back(we ? st : 4'h0);
        e_wdata.push_back(wd);
        if (!we) e_dc_data.push_back(rom(a & ~32'h3));
        e_n_dc++;
        e_gnt.push_back(1);
        m_last_dc = 1'b1;
    endtask

    // Model: simultaneous requests go to the side that lost last time
    task automatic expect_tie(input logic [31:0] ia, input logic we, input logic [31:0] da,
                              input logic [31:0] wd, input logic [3:0] st);
        if (m_last_dc) begin
            expect_ic(ia);
            expect_dc(we, da, wd, st);
        end else begin
            expect_dc(we, da, wd, st);
            expect_ic(ia);
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!(ic_done_n >= e_n_ic && dc_done_n >= e_n_dc) && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_finished_in_budget"}, 64'(ic_done_n >= e_n_ic && dc_done_n >= e_n_dc), 64'd1);
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_beats"}, 64'(acc_addr.size()), 64'(e_addr.size()));
        for (int i = 0; i < acc_addr.size() && i < e_addr.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 64'(acc_addr[i]), 64'(e_addr[i]));
            chk($sformatf("%s_we%0d", tag, i), 64'(acc_we[i]), 64'(e_we[i]));
            chk($sformatf("%s_strb%0d", tag, i), 64'(acc_strb[i]), 64'(e_strb[i]));
            if (e_we[i]) chk($sformatf("%s_wdata%0d", tag, i), 64'(acc_wdata[i]), 64'(e_wdata[i]));
        end
        chk({tag, "_ic_rvalid_n"}, 64'(ic_data.size()), 64'(e_ic_data.size()));
        for (int i = 0; i < ic_data.size() && i < e_ic_data.size(); i++)
            chk($sformatf("%s_ic_rdata%0d", tag, i), 64'(ic_data[i]), 64'(e_ic_data[i]));
        chk({tag, "_dc_rvalid_n"}, 64'(dc_data.size()), 64'(e_dc_data.size()));
        for (int i = 0; i < dc_data.size() && i < e_dc_data.size(); i++)
            chk($sformatf("%s_dc_rdata%0d", tag, i), 64'(dc_data[i]), 64'(e_dc_data[i]));
        chk({tag, "_grants"}, 64'(gnt_log.size()), 64'(e_gnt.size()));
        for (int i = 0; i < gnt_log.size() && i < e_gnt.size(); i++)
            chk($sformatf("%s_gnt_is_dc%0d", tag, i), 64'(gnt_log[i]), 64'(e_gnt[i]));
        chk({tag, "_ic_done_n"}, 64'(ic_done_n), 64'(e_n_ic));
        chk({tag, "_dc_done_n"}, 64'(dc_done_n), 64'(e_n_dc));
        chk({tag, "_protocol_errs"}, 64'(proto_err), 64'd0);
        chk({tag, "_addr_hold_errs"}, 64'(hold_err), 64'd0);
        chk({tag, "_req_at_done_errs"}, 64'(idle_err), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({ic_gnt, ic_rvalid, ic_done, dc_gnt, dc_rvalid, dc_done,
                                 mem_req, mem_we}), 64'd0);
        chk({tag, "_ic_rdata"}, 64'(ic_rdata), 64'd0);
        chk({tag, "_dc_rdata"}, 64'(dc_rdata), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_mem_wdata_wstrb"}, {28'd0, mem_wdata, mem_wstrb}, 64'd0);
    endtask

    typedef struct {
        bit          is_dc;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_addr0;
        bit          exp_we;
        logic [3:0]  exp_strb;
        int          exp_beats;
        int          exp_rvalid;
    } vec_t;

    vec_t vecs[7];

    // Watchdog: never let the run hang
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int kind, dly;
        bit first_dc;
        logic [31:0] ra, da, wd;
        logic rwe;
        logic [3:0] rst_b;
        bit found;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_001C, 32'h0, 4'h0, 32'h0000_0010, 1'b0, 4'h0, 4, 4};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_1234, 32'h0, 4'h0, 32'h0000_1230, 1'b0, 4'h0, 4, 4};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_2003, 32'hDEAD_BEEF, 4'b0011, 32'h0000_2000, 1'b1, 4'b0011, 1, 0};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_4006, 32'h1111_1111, 4'hF, 32'h0000_4004, 1'b0, 4'h0, 1, 1};
        vecs[4] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'hFFFF_FFF0, 1'b0, 4'h0, 4, 4};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678, 4'hF, 32'h0000_0008, 1'b1, 4'hF, 1, 0};
        vecs[6] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 4'h0, 32'hFFFF_FFFC, 1'b0, 4'h0, 1, 1};

        rst = 1'b0; ic_req = 1'b0; ic_addr = '0; dc_req = 1'b0; dc_we = 1'b0;
        dc_addr = '0; dc_wdata = '0; dc_wstrb = '0; mem_ready = 1'b1;
        clear_logs();
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        m_last_dc = 1'b0;

        // Lone refill: aligned line walk, latency and done on the last beat
        clear_logs();
        c0 = cyc;
        launch_ic(32'h0000_001C);
        expect_ic(32'h0000_001C);
        wait_done("lone_refill", 40);
        compare_all("lone_refill");
        chk("lone_refill_gnt_cycle", 64'(ic_gnt_cyc), 64'(c0 + 1));
        chk("lone_refill_last_rvalid_cycle", 64'(last_ic_rv_cyc), 64'(c0 + 1 + LW));
        chk("lone_refill_done_with_last", 64'(ic_done_cyc), 64'(last_ic_rv_cyc));

        // First tie after reset: DCache wins, ICache follows after one idle cycle
        clear_logs();
        c0 = cyc;
        launch_ic(32'h0000_0040);
        launch_dc(1'b0, 32'h0000_0104, 32'h0, 4'h0);
        expect_tie(32'h0000_0040, 1'b0, 32'h0000_0104, 32'h0, 4'h0);
        wait_done("tie1", 60);
        compare_all("tie1");
        chk("tie1_dc_gnt_cycle", 64'(dc_gnt_cyc), 64'(c0 + 1));
        chk("tie1_ic_gnt_after_idle", 64'(ic_gnt_cyc), 64'(dc_done_cyc + 1));

        // Lone DCache write, then a second tie which now favours the ICache
        clear_logs();
        launch_dc(1'b1, 32'h0000_0300, 32'hCAFE_F00D, 4'hF);
        expect_dc(1'b1, 32'h0000_0300, 32'hCAFE_F00D, 4'hF);
        wait_done("dc_lone", 20);
        compare_all("dc_lone");
        clear_logs();
        c0 = cyc;
        launch_ic(32'h0000_0080);
        launch_dc(1'b0, 32'h0000_0208, 32'h0, 4'h0);
        expect_tie(32'h0000_0080, 1'b0, 32'h0000_0208, 32'h0, 4'h0);
        wait_done("tie2", 60);
        compare_all("tie2");
        chk("tie2_ic_gnt_cycle", 64'(ic_gnt_cyc), 64'(c0 + 1));
        chk("tie2_dc_gnt_after_idle", 64'(dc_gnt_cyc), 64'(ic_done_cyc + 1));

        // Directed vector table
        for (int v = 0; v < 7; v++) begin
            clear_logs();
            if (vecs[v].is_dc) begin
                launch_dc(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].strb);
                expect_dc(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].strb);
            end else begin
                launch_ic(vecs[v].addr);
                expect_ic(vecs[v].addr);
            end
            wait_done($sformatf("vec%0d", v), 40);
            chk($sformatf("vec%0d_nbeats", v), 64'(acc_addr.size()), 64'(vecs[v].exp_beats));
            if (acc_addr.size() > 0) begin
                chk($sformatf("vec%0d_first_addr", v), 64'(acc_addr[0]), 64'(vecs[v].exp_addr0));
                chk($sformatf("vec%0d_last_addr", v), 64'(acc_addr[acc_addr.size()-1]),
                    64'(vecs[v].exp_addr0 + 32'(4 * (vecs[v].exp_beats - 1))));
                chk($sformatf("vec%0d_we", v), 64'(acc_we[0]), 64'(vecs[v].exp_we));
                chk($sformatf("vec%0d_wstrb", v), 64'(acc_strb[0]), 64'(vecs[v].exp_strb));
                if (vecs[v].exp_we)
                    chk($sformatf("vec%0d_wdata", v), 64'(acc_wdata[0]), 64'(vecs[v].wdata));
            end
            chk($sformatf("vec%0d_rvalid_n", v), 64'(ic_data.size() + dc_data.size()),
                64'(vecs[v].exp_rvalid));
            compare_all($sformatf("vec%0d", v));
        end

        // Wait states: ready alternates 0/1 during a refill
        ready_mode = 1;
        clear_logs();
        launch_ic(32'h0000_5008);
        expect_ic(32'h0000_5008);
        wait_done("waitst", 60);
        compare_all("waitst");
        chk("waitst_req_cycles", 64'(req_cnt), 64'(2 * LW));
        ready_mode = 0;

        // Reset asserted while beat 2 is on the bus
        clear_logs();
        launch_ic(32'h0000_7000);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (mem_req && mem_addr == 32'h0000_7008) found = 1'b1;
        end
        chk("rst_mid_reached_beat2", 64'(found), 64'd1);
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        tick();
        rst = 1'b0;
        m_last_dc = 1'b0;
        repeat (5) tick();
        chk("rst_mid_no_done", 64'(ic_done_n), 64'd0);
        clear_logs();
        launch_ic(32'h0000_7000);
        expect_ic(32'h0000_7000);
        wait_done("rst_restart", 40);
        compare_all("rst_restart");

        // Request dropped (and address scrambled) right after grant
        clear_logs();
        launch_ic(32'h0000_9010);
        expect_ic(32'h0000_9010);
        wait_done("req_drop", 40);
        compare_all("req_drop");

        // Randomized traffic against the transaction model
        ready_mode = 2;
        for (int it = 0; it < 30; it++) begin
            clear_logs();
            kind     = $urandom_range(0, 2);
            dly      = $urandom_range(0, 2);
            first_dc = 1'($urandom);
            ra  = $urandom;
            da  = $urandom;
            wd  = $urandom;
            rwe = 1'($urandom);
            rst_b = 4'($urandom);
            if (kind == 0) begin
                launch_ic(ra);
                expect_ic(ra);
            end else if (kind == 1) begin
                launch_dc(rwe, da, wd, rst_b);
                expect_dc(rwe, da, wd, rst_b);
            end else if (dly == 0) begin
                launch_ic(ra);
                launch_dc(rwe, da, wd, rst_b);
                expect_tie(ra, rwe, da, wd, rst_b);
            end else if (first_dc) begin
                launch_dc(rwe, da, wd, rst_b);
                expect_dc(rwe, da, wd, rst_b);
                repeat (dly) tick();
                launch_ic(ra);
                expect_ic(ra);
            end else begin
                launch_ic(ra);
                expect_ic(ra);
                repeat (dly) tick();
                launch_dc(rwe, da, wd, rst_b);
                expect_dc(rwe, da, wd, rst_b);
            end
            wait_done($sformatf("rnd%0d", it), 300);
            compare_all($sformatf("rnd%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
